// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and constants for the life sequencer slice
//
// Purpose: state encoding and grid geometry shared by the sequencer and its
// tick divider.
// Ports: none (package).
package life_pkg;

  localparam int GRID_W           = 64;
  localparam int ROW_W            = 8;
  localparam int TICK_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/life_sequencer_tick_divider.sv
// rtl/life_sequencer_tick_divider.sv - generation pacing counter for RUN mode
//
// Purpose: counts 0..DIV-1 while enabled and wraps; tc marks the last count.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   clear  in   synchronous clear of the count (wins over enable)
//   enable in   advance the count this cycle
//   tc     out  terminal count: enable && count == DIV-1
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  // DIV == 1 still needs a one-bit counter that simply never leaves zero.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = enable && (cnt == LAST);

endmodule

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - load/run/step/pause sequencer around the life datapath
//
// Purpose: owns the current-grid register, applies one generation per STEP or
// per divider tick in RUN, counts generations (saturating) and halts on
// extinction or still life. Optional period-2 detection under the macro
// LIFE_OSC2_DETECT_EN.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   seed[63:0]   in   initial pattern, bit r*8+c = cell (row r, col c)
//   load         in   capture seed (highest priority command)
//   run          in   start free-running evolution
//   step         in   advance exactly one generation
//   pause        in   stop RUN, back to IDLE
//   grid_evolve  in   next generation from the combinational datapath
//   grid         out  current grid register
//   gen_count    out  generations applied since last load
//   busy         out  state is RUN or STEP
//   done         out  state is HALT
//   extinct      out  halted because the grid was empty
//   stable       out  halted because the grid was a still life
//   osc2         out  halted on a period-2 pattern (LIFE_OSC2_DETECT_EN only)
module life_sequencer
  import life_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int GEN_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       seed,
  input  logic              load,
  input  logic              run,
  input  logic              step,
  input  logic              pause,
  input  logic [63:0]       grid_evolve,
  output logic [63:0]       grid,
  output logic [GEN_W-1:0]  gen_count,
  output logic              busy,
  output logic              done,
  output logic              extinct,
`ifdef LIFE_OSC2_DETECT_EN
  output logic              osc2,
`endif
  output logic              stable
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] STEP = ST_STEP;
  localparam logic [1:0] HALT = ST_HALT;

  logic [1:0]       state;
  logic             tick;
  logic             advance;
  logic             is_empty;
  logic             is_still;
  logic             halt_now;
  logic [GEN_W-1:0] gen_next;

  // The divider only counts in RUN; it is held at zero everywhere else so a
  // run command always starts a full TICK_DIV period.
  tick_divider #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state != RUN) || load || pause),
    .enable (state == RUN),
    .tc     (tick)
  );

  // Update point: the single STEP cycle, or a divider tick in RUN that is not
  // pre-empted by load/pause.
  assign advance = !load && ((state == STEP) || ((state == RUN) && !pause && tick));

  assign is_empty = (grid == '0);
  assign is_still = (grid_evolve == grid);

`ifdef LIFE_OSC2_DETECT_EN
  logic [63:0] prev_grid;
  logic        is_osc2;

  // Needs two applied generations so prev_grid holds a real ancestor.
  assign is_osc2  = (grid_evolve == prev_grid) && (gen_count > GEN_W'(1));
  assign halt_now = is_empty || is_still || is_osc2;
`else
  assign halt_now = is_empty || is_still;
`endif

  assign gen_next = (gen_count == {GEN_W{1'b1}}) ? gen_count : gen_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grid      <= '0;
      gen_count <= '0;
      extinct   <= 1'b0;
      stable    <= 1'b0;
    end else if (load) begin
      state     <= IDLE;
      grid      <= seed;
      gen_count <= '0;
      extinct   <= 1'b0;
      stable    <= 1'b0;
    end else if (advance) begin
      if (halt_now) begin
        // Causes are prioritised: empty, then still, then period-2.
        state <= HALT;
        if (is_empty) begin
          extinct <= 1'b1;
        end else if (is_still) begin
          stable <= 1'b1;
        end
      end else begin
        grid      <= grid_evolve;
        gen_count <= gen_next;
        state     <= (state == STEP) ? IDLE : state;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!pause) begin
            if (step) begin
              state <= STEP;
            end else if (run) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state <= IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LIFE_OSC2_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset || load) begin
      prev_grid <= '0;
      osc2      <= 1'b0;
    end else if (advance) begin
      if (!halt_now) begin
        prev_grid <= grid;
      end else if (!is_empty && !is_still) begin
        osc2 <= 1'b1;
      end
    end
  end
`endif

  assign busy = (state == RUN) || (state == STEP);
  assign done = (state == HALT);

endmodule

// File: tb/tb_life_sequencer.sv
// tb/tb_life_sequencer.sv - directed vector bench for life_sequencer
module tb_life_sequencer;

  localparam int GW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [63:0]    seed = '0;
  logic           load = 1'b0;
  logic           run = 1'b0;
  logic           step = 1'b0;
  logic           pause = 1'b0;
  logic [63:0]    grid_evolve;
  logic [63:0]    grid;
  logic [GW-1:0]  gen_count;
  logic           busy, done, extinct, stable;
`ifdef LIFE_OSC2_DETECT_EN
  logic           osc2;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0E00;
  localparam logic [63:0] BLINK_V = 64'h0000_0000_0004_0404;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;

  always #5 clk = ~clk;

  life_sequencer #(.TICK_DIV(4), .GEN_W(GW)) dut (
    .clk         (clk),
    .reset       (reset),
    .seed        (seed),
    .load        (load),
    .run         (run),
    .step        (step),
    .pause       (pause),
    .grid_evolve (grid_evolve),
    .grid        (grid),
    .gen_count   (gen_count),
    .busy        (busy),
    .done        (done),
    .extinct     (extinct),
`ifdef LIFE_OSC2_DETECT_EN
    .osc2        (osc2),
`endif
    .stable      (stable)
  );

  // Reference datapath: standard B3/S23 rules, cells outside the 8x8 are dead.
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int nb, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        nb = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              if (g[rr*8+cc]) nb++;
          end
        end
        n[r*8+c] = (nb == 3) || (g[r*8+c] && nb == 2);
      end
    end
    return n;
  endfunction

  always_comb grid_evolve = life_next(grid);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic l, input logic r, input logic s, input logic p, input logic [63:0] sd);
    load = l; run = r; step = s; pause = p; seed = sd;
  endtask

  task automatic chk_all(input string tag, input logic [63:0] g, input int gc,
                         input logic bz, input logic dn, input logic ex, input logic sb);
    chk({tag, ".grid"}, grid, g);
    chk({tag, ".gen"}, 64'(gen_count), 64'(gc));
    chk({tag, ".busy"}, 64'(busy), 64'(bz));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".extinct"}, 64'(extinct), 64'(ex));
    chk({tag, ".stable"}, 64'(stable), 64'(sb));
  endtask

  typedef struct {
    logic        ld, rn, st, ps;
    logic [63:0] sd;
    logic [63:0] g;
    int          gc;
    logic        bz, dn, ex, sb;
  } vec_t;

  function automatic vec_t mk(logic ld, logic rn, logic st, logic ps, logic [63:0] sd,
                              logic [63:0] g, int gc, logic bz, logic dn, logic ex, logic sb);
    vec_t v;
    v.ld = ld; v.rn = rn; v.st = st; v.ps = ps; v.sd = sd;
    v.g = g; v.gc = gc; v.bz = bz; v.dn = dn; v.ex = ex; v.sb = sb;
    return v;
  endfunction

  vec_t vecs[$];
  int   seen;

  initial begin
    // Each vector: inputs for one cycle, outputs expected after that edge.
    //            ld rn st ps seed      grid     gen bz dn ex sb
    vecs.push_back(mk(1, 0, 0, 0, BLINK_H, BLINK_H, 0, 0, 0, 0, 0)); // load blinker
    vecs.push_back(mk(0, 0, 1, 0, 0,       BLINK_H, 0, 1, 0, 0, 0)); // step accepted
    vecs.push_back(mk(0, 0, 0, 0, 0,       BLINK_V, 1, 0, 0, 0, 0)); // STEP applied
    vecs.push_back(mk(0, 0, 1, 0, 0,       BLINK_V, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       BLINK_H, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0,       BLINK_H, 2, 0, 0, 0, 0)); // pause in IDLE
    vecs.push_back(mk(0, 1, 1, 1, 0,       BLINK_H, 2, 0, 0, 0, 0)); // pause beats step/run
    vecs.push_back(mk(1, 0, 0, 0, BLOCK,   BLOCK,   0, 0, 0, 0, 0)); // load block
    vecs.push_back(mk(0, 1, 0, 0, 0,       BLOCK,   0, 1, 0, 0, 0)); // run, cnt 0
    vecs.push_back(mk(0, 0, 0, 0, 0,       BLOCK,   0, 1, 0, 0, 0)); // cnt 1
    vecs.push_back(mk(0, 0, 0, 0, 0,       BLOCK,   0, 1, 0, 0, 0)); // cnt 2
    vecs.push_back(mk(0, 0, 0, 0, 0,       BLOCK,   0, 1, 0, 0, 0)); // cnt 3
    vecs.push_back(mk(0, 0, 0, 0, 0,       BLOCK,   0, 0, 1, 0, 1)); // tick: still life
    vecs.push_back(mk(0, 1, 1, 1, 0,       BLOCK,   0, 0, 1, 0, 1)); // HALT ignores these
    vecs.push_back(mk(1, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0)); // load empty, flags clear
    vecs.push_back(mk(0, 0, 1, 0, 0,       0,       0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       0,       0, 0, 1, 1, 0)); // extinct halt
    vecs.push_back(mk(1, 1, 1, 1, BLINK_H, BLINK_H, 0, 0, 0, 0, 0)); // load wins
    vecs.push_back(mk(0, 0, 0, 0, 0,       BLINK_H, 0, 0, 0, 0, 0));

    cyc();
    cyc();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      cmd(vecs[i].ld, vecs[i].rn, vecs[i].st, vecs[i].ps, vecs[i].sd);
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].gc,
              vecs[i].bz, vecs[i].dn, vecs[i].ex, vecs[i].sb);
    end
    cmd(0, 0, 0, 0, 0);

`ifndef LIFE_OSC2_DETECT_EN
    // RUN pacing: run accepted on edge 1, updates on edges 5, 9, 13, 17.
    cmd(0, 1, 0, 0, 0);
    cyc();
    cmd(0, 0, 0, 0, 0);
    chk("run.accept.busy", 64'(busy), 64'd1);
    for (int k = 2; k <= 17; k++) begin
      cyc();
      if (k == 4) chk("run.edge4.gen", 64'(gen_count), 64'd0);
      if (k == 5) chk("run.edge5.grid", grid, BLINK_V);
      if (k == 5) chk("run.edge5.gen", 64'(gen_count), 64'd1);
      if (k == 8) chk("run.edge8.grid", grid, BLINK_V);
    end
    chk_all("run17", BLINK_H, 4, 1, 0, 0, 0);
    cmd(0, 0, 0, 1, 0);
    cyc();
    cmd(0, 0, 0, 0, 0);
    chk_all("paused", BLINK_H, 4, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc();
    chk_all("paused.hold", BLINK_H, 4, 0, 0, 0, 0);

    // Saturation: 9 steps with a 3-bit counter stops at 7, evolution goes on.
    for (int k = 0; k < 9; k++) begin
      cmd(0, 0, 1, 0, 0);
      cyc();
      cmd(0, 0, 0, 0, 0);
      cyc();
    end
    chk_all("saturate", BLINK_V, 7, 0, 0, 0, 0);
`endif

    // Simultaneous load+run+pause while in RUN: seed loaded, back to IDLE.
    cmd(1, 0, 0, 0, BLINK_H);
    cyc();
    cmd(0, 1, 0, 0, 0);
    cyc();
    cmd(0, 0, 0, 0, 0);
    cyc();
    cyc();
    cmd(1, 1, 0, 1, BLOCK);
    cyc();
    cmd(0, 0, 0, 0, 0);
    chk_all("prio.run", BLOCK, 0, 0, 0, 0, 0);
    cyc();
    chk("prio.idle.busy", 64'(busy), 64'd0);

`ifdef LIFE_OSC2_DETECT_EN
    // Blinker in RUN halts as period-2 once two generations are applied.
    cmd(1, 0, 0, 0, BLINK_H);
    cyc();
    cmd(0, 1, 0, 0, 0);
    cyc();
    cmd(0, 0, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc();
      seen++;
    end
    chk("osc2.halt_edge", 64'(seen), 64'd12);
    chk("osc2.flag", 64'(osc2), 64'd1);
    chk_all("osc2", BLINK_H, 2, 0, 1, 0, 0);
    cmd(1, 0, 0, 0, BLINK_H);
    cyc();
    cmd(0, 0, 0, 0, 0);
    chk("osc2.load_clear", 64'(osc2), 64'd0);
`endif

    // Reset mid-RUN beats a concurrent load.
    cmd(1, 0, 0, 0, BLINK_H);
    cyc();
    cmd(0, 1, 0, 0, 0);
    cyc();
    cmd(0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("midrun.busy", 64'(busy), 64'd1);
    reset = 1'b1;
    cmd(1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    reset = 1'b0;
    cmd(0, 0, 0, 0, 0);
    chk_all("midrun.reset", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
